alu_issue_stage: RTL and testbench

Operand-fetch and issue stage directly upstream of the combinational ALU. It accepts one decoded ALU instruction per cycle and reads its source registers through the register-file read ports, applying writeback bypass. It holds the instruction while a 32-entry scoreboard reports a hazard. It then presents registered operands (`is_imm`, `val1`, `val2`, `funct`) plus the destination index to the ALU and downstream result stage over a valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 147 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand fetch and issue stage in front of the combinational ALU.
// Reads rs1/rs2 through the register-file ports, applies writeback bypass, and
// holds the instruction while a 32-entry busy scoreboard reports a RAW/WAW hazard.
// Issued operands sit in output registers behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    // decoded instruction
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_imm,
    input  logic [4:0]       in_funct,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [IMM_W-1:0] in_imm,
    // register file read ports
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [31:0]      rf_rdata1,
    input  logic [31:0]      rf_rdata2,
    // writeback
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    // ALU side
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic             alu_is_imm,
    output logic [4:0]       alu_funct,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [4:0]       alu_rd,
    // statistics
    output logic [31:0]      stall_cycles
);

    logic [31:0] busy_q, busy_d;
    logic [31:0] eff_busy;
    logic        hazard;
    logic        issue;
    logic [31:0] op1, op2, imm_ext;

    logic        alu_valid_q;
    logic        alu_is_imm_q;
    logic [4:0]  alu_funct_q;
    logic [31:0] alu_val1_q, alu_val2_q;
    logic [4:0]  alu_rd_q;
    logic [31:0] stall_q;

    // Source operand: x0 reads zero, a same-cycle writeback beats the register file.
    function automatic logic [31:0] src_operand(input logic [4:0]  rs,
                                                input logic [31:0] rf,
                                                input logic        wbv,
                                                input logic [4:0]  wbr,
                                                input logic [31:0] wbd);
        if (rs == 5'd0)
            return 32'd0;
        else if (wbv && wbr == rs)
            return wbd;
        else
            return rf;
    endfunction

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // Busy bits as seen this cycle: a retiring write already frees its register.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no latch is inferred.
        eff_busy = busy_q;
        if (wb_valid)
            eff_busy[wb_rd] = 1'b0;
    end

    assign hazard   = eff_busy[in_rs1] | (~in_is_imm & eff_busy[in_rs2]) | eff_busy[in_rd];
    assign in_ready = ~hazard & (~alu_valid_q | alu_ready);
    assign issue    = in_valid & in_ready;

    // Operand selection; add/sub immediates sign-extend, shift amounts zero-extend.
    always_comb begin
        imm_ext = (in_funct[1:0] != 2'b00) ? 32'($signed(in_imm)) : 32'(in_imm);
        op1     = src_operand(in_rs1, rf_rdata1, wb_valid, wb_rd, wb_data);
        op2     = in_is_imm ? imm_ext
                            : src_operand(in_rs2, rf_rdata2, wb_valid, wb_rd, wb_data);
    end

    // Scoreboard next state: writeback clears, issue sets and wins on the same index.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid)
            busy_d[wb_rd] = 1'b0;
        if (issue && in_rd != 5'd0)
            busy_d[in_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the scoreboard is reset like any other flop; stale busy bits would deadlock issue.
        if (!rstn)
            busy_q <= '0;
        else
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            busy_q <= busy_d;
    end

    // Output stage: load on issue, drop valid when consumed without a replacement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_valid_q  <= 1'b0;
            alu_is_imm_q <= 1'b0;
            alu_funct_q  <= '0;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_rd_q     <= '0;
        end else if (issue) begin
            alu_valid_q  <= 1'b1;
            alu_is_imm_q <= in_is_imm;
            alu_funct_q  <= in_funct;
            alu_val1_q   <= op1;
            alu_val2_q   <= op2;
            alu_rd_q     <= in_rd;
        end else if (alu_ready) begin
            alu_valid_q  <= 1'b0;
        end
    end

    // Saturating count of cycles where an offered instruction was not accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_q <= '0;
        else if (in_valid && !in_ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign alu_valid    = alu_valid_q;
    assign alu_is_imm   = alu_is_imm_q;
    assign alu_funct    = alu_funct_q;
    assign alu_val1     = alu_val1_q;
    assign alu_val2     = alu_val2_q;
    assign alu_rd       = alu_rd_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_alu_issue_stage;

    localparam int IMM_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_is_imm = 1'b0;
    logic [4:0]       in_funct = '0;
    logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [IMM_W-1:0] in_imm = '0;
    logic [4:0]       rf_raddr1, rf_raddr2;
    logic [31:0]      rf_rdata1 = '0, rf_rdata2 = '0;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic [31:0]      wb_data = '0;
    logic             alu_valid;
    logic             alu_ready = 1'b1;
    logic             alu_is_imm;
    logic [4:0]       alu_funct;
    logic [31:0]      alu_val1, alu_val2;
    logic [4:0]       alu_rd;
    logic [31:0]      stall_cycles;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.IMM_W(IMM_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_imm(in_is_imm),
        .in_funct(in_funct), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_is_imm(alu_is_imm),
        .alu_funct(alu_funct), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_rd(alu_rd), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        wb_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic drive(input logic is_imm, input logic [4:0] funct, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [15:0] imm,
                         input logic [31:0] rf1, input logic [31:0] rf2);
        in_valid  = 1'b1;
        in_is_imm = is_imm;
        in_funct  = funct;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm    = imm;
        rf_rdata1 = rf1;
        rf_rdata2 = rf2;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        is_imm;
        logic [4:0]  funct, rs1, rs2, rd;
        logic [15:0] imm;
        logic [31:0] rf1, rf2;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t vecs[9];

    // ---------------- behavioural model ----------------
    bit          busy_m[32];
    bit          m_valid;
    logic        m_is_imm;
    logic [4:0]  m_funct, m_rd;
    logic [31:0] m_v1, m_v2;
    logic [31:0] m_stall;

    function automatic logic [31:0] ref_src(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (wb_valid && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [4:0] funct);
        int v;
        v = int'(imm);
        if (funct[1:0] != 0 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic bit reg_busy_now(input logic [4:0] r);
        return busy_m[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit ref_ready();
        bit haz;
        haz = reg_busy_now(in_rs1) || (!in_is_imm && reg_busy_now(in_rs2)) || reg_busy_now(in_rd);
        return !haz && (!m_valid || alu_ready);
    endfunction

    initial begin
        logic [31:0] s0;
        bit          rdy;

        vecs[0] = '{1'b1, 5'b00001, 5'd3, 5'd0, 5'd5, 16'hFFFF, 32'd10, 32'd0, 1'b0, 5'd0, 32'd0, 32'd10, 32'hFFFF_FFFF};
        vecs[1] = '{1'b1, 5'b00100, 5'd4, 5'd0, 5'd5, 16'h8001, 32'h0000_ABCD, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0000_ABCD, 32'h0000_8001};
        vecs[2] = '{1'b1, 5'b00010, 5'd4, 5'd0, 5'd5, 16'h8001, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'hFFFF_8001};
        vecs[3] = '{1'b1, 5'b01000, 5'd0, 5'd0, 5'd5, 16'h7FFF, 32'hDEAD_BEEF, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h0000_7FFF};
        vecs[4] = '{1'b0, 5'b00001, 5'd2, 5'd9, 5'd5, 16'h0000, 32'd11, 32'd22, 1'b0, 5'd0, 32'd0, 32'd11, 32'd22};
        vecs[5] = '{1'b0, 5'b00001, 5'd5, 5'd6, 5'd8, 16'h0000, 32'd1, 32'd2, 1'b1, 5'd5, 32'h1234, 32'h1234, 32'd2};
        vecs[6] = '{1'b0, 5'b00010, 5'd0, 5'd6, 5'd8, 16'h0000, 32'hBAD0_BAD0, 32'd2, 1'b1, 5'd6, 32'd77, 32'd0, 32'd77};
        vecs[7] = '{1'b1, 5'b00001, 5'd6, 5'd6, 5'd8, 16'h0005, 32'd3, 32'd4, 1'b1, 5'd6, 32'd99, 32'd99, 32'd5};
        vecs[8] = '{1'b0, 5'b10000, 5'd0, 5'd0, 5'd8, 16'h0000, 32'hFFFF_0000, 32'h1111_1111, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0};

        // ---- reset state ----
        do_reset();
        check("reset_alu_valid", 32'(alu_valid), 32'd0);
        check("reset_val1", alu_val1, 32'd0);
        check("reset_val2", alu_val2, 32'd0);
        check("reset_funct", 32'(alu_funct), 32'd0);
        check("reset_is_imm", 32'(alu_is_imm), 32'd0);
        check("reset_rd", 32'(alu_rd), 32'd0);
        check("reset_stall", stall_cycles, 32'd0);

        // ---- vector table, one issue per fresh reset ----
        for (int i = 0; i < 9; i++) begin
            do_reset();
            alu_ready = 1'b1;
            drive(vecs[i].is_imm, vecs[i].funct, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].imm, vecs[i].rf1, vecs[i].rf2);
            wb_valid = vecs[i].wbv;
            wb_rd    = vecs[i].wbrd;
            wb_data  = vecs[i].wbd;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d_raddr1", i), 32'(rf_raddr1), 32'(vecs[i].rs1));
            check($sformatf("vec%0d_raddr2", i), 32'(rf_raddr2), 32'(vecs[i].rs2));
            cyc();
            in_valid = 1'b0;
            wb_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(alu_valid), 32'd1);
            check($sformatf("vec%0d_val1", i), alu_val1, vecs[i].e1);
            check($sformatf("vec%0d_val2", i), alu_val2, vecs[i].e2);
            check($sformatf("vec%0d_rd", i), 32'(alu_rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_funct", i), 32'(alu_funct), 32'(vecs[i].funct));
            check($sformatf("vec%0d_is_imm", i), 32'(alu_is_imm), 32'(vecs[i].is_imm));
        end

        // ---- RAW stall, then issue on the producer's writeback via bypass ----
        do_reset();
        alu_ready = 1'b1;
        drive(1'b1, 5'b00001, 5'd3, 5'd0, 5'd5, 16'hFFFF, 32'd10, 32'd0);
        cyc();
        check("raw_first_val2", alu_val2, 32'hFFFF_FFFF);
        drive(1'b0, 5'b00001, 5'd5, 5'd1, 5'd6, 16'h0000, 32'hAAAA_AAAA, 32'd1);
        #1;
        check("raw_stall_ready", 32'(in_ready), 32'd0);
        cyc();
        check("raw_stall_cnt1", stall_cycles, 32'd1);
        cyc();
        check("raw_stall_cnt2", stall_cycles, 32'd2);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'h1234;
        #1;
        check("raw_wb_ready", 32'(in_ready), 32'd1);
        cyc();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        check("raw_bypass_val1", alu_val1, 32'h1234);
        check("raw_bypass_rd", 32'(alu_rd), 32'd6);
        check("raw_stall_final", stall_cycles, 32'd2);

        // ---- rd=0 never marks x0 busy ----
        do_reset();
        drive(1'b1, 5'b00100, 5'd0, 5'd0, 5'd0, 16'h8001, 32'hDEAD_BEEF, 32'd0);
        cyc();
        check("x0_val1", alu_val1, 32'd0);
        check("x0_val2", alu_val2, 32'h0000_8001);
        drive(1'b0, 5'b00001, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h5555_5555, 32'h6666_6666);
        #1;
        check("x0_not_busy", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;

        // ---- downstream backpressure for three cycles ----
        do_reset();
        drive(1'b1, 5'b00001, 5'd1, 5'd0, 5'd2, 16'h0001, 32'd100, 32'd0);
        cyc();
        s0 = stall_cycles;
        drive(1'b1, 5'b00001, 5'd3, 5'd0, 5'd4, 16'h0002, 32'd200, 32'd0);
        alu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'd0);
            cyc();
            check($sformatf("bp_hold_val1_%0d", k), alu_val1, 32'd100);
            check($sformatf("bp_hold_rd_%0d", k), 32'(alu_rd), 32'd2);
            check($sformatf("bp_hold_valid_%0d", k), 32'(alu_valid), 32'd1);
        end
        check("bp_stall_plus3", stall_cycles, s0 + 32'd3);
        alu_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("bp_replace_val1", alu_val1, 32'd200);
        check("bp_replace_rd", 32'(alu_rd), 32'd4);

        // ---- same-cycle set/clear on rd=7, then WAW stall ----
        do_reset();
        drive(1'b1, 5'b00001, 5'd1, 5'd0, 5'd7, 16'h0000, 32'd1, 32'd0);
        cyc();
        drive(1'b1, 5'b00001, 5'd2, 5'd0, 5'd7, 16'h0000, 32'd2, 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 32'd0;
        #1;
        check("waw_retire_ready", 32'(in_ready), 32'd1);
        cyc();
        wb_valid = 1'b0;
        drive(1'b1, 5'b00001, 5'd3, 5'd0, 5'd7, 16'h0000, 32'd3, 32'd0);
        #1;
        check("waw_stall_ready", 32'(in_ready), 32'd0);
        cyc();
        check("waw_stall_cnt", stall_cycles, 32'd1);

        // ---- asynchronous reset in the middle of the stall ----
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", 32'(alu_valid), 32'd0);
        check("async_rst_stall", stall_cycles, 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(alu_valid), 32'd1);
        check("post_rst_rd", 32'(alu_rd), 32'd7);
        check("post_rst_val1", alu_val1, 32'd3);

        // ---- randomized traffic against the model ----
        do_reset();
        foreach (busy_m[r]) busy_m[r] = 1'b0;
        m_valid = 1'b0; m_is_imm = 1'b0; m_funct = '0; m_rd = '0;
        m_v1 = '0; m_v2 = '0; m_stall = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_is_imm = $urandom_range(0, 1);
            in_funct  = 5'(1 << $urandom_range(0, 4));
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_rd     = 5'($urandom_range(0, 7));
            in_imm    = 16'($urandom);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            alu_ready = ($urandom_range(0, 9) < 7);
            #1;
            rdy = ref_ready();
            check("rnd_in_ready", 32'(in_ready), 32'(rdy));
            check("rnd_raddr1", 32'(rf_raddr1), 32'(in_rs1));
            // model next state from the rules
            if (in_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (wb_valid) busy_m[wb_rd] = 1'b0;
            if (in_valid && rdy) begin
                m_valid  = 1'b1;
                m_is_imm = in_is_imm;
                m_funct  = in_funct;
                m_rd     = in_rd;
                m_v1     = ref_src(in_rs1, rf_rdata1);
                m_v2     = in_is_imm ? ref_imm(in_imm, in_funct) : ref_src(in_rs2, rf_rdata2);
                if (in_rd != 0) busy_m[in_rd] = 1'b1;
            end else if (alu_ready) begin
                m_valid = 1'b0;
            end
            cyc();
            check("rnd_alu_valid", 32'(alu_valid), 32'(m_valid));
            check("rnd_stall", stall_cycles, m_stall);
            if (m_valid) begin
                check("rnd_val1", alu_val1, m_v1);
                check("rnd_val2", alu_val2, m_v2);
                check("rnd_rd", 32'(alu_rd), 32'(m_rd));
                check("rnd_funct", 32'(alu_funct), 32'(m_funct));
                check("rnd_is_imm", 32'(alu_is_imm), 32'(m_is_imm));
            end
        end
        in_valid = 1'b0;
        wb_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
